// File: rtl/sdram_pro_arbit_pkg.sv
// Shared types for the SDRAM command-bus arbiter: FSM states, SDRAM command
// encodings ({cs_n,ras_n,cas_n,we_n}) and the grant vector.
package sdram_pro_arbit_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_e;

  typedef enum logic [3:0] {
    SD_MODE_REG_SET  = 4'b0000,
    SD_AUTO_REFRESH  = 4'b0001,
    SD_PRECHARGE     = 4'b0010,
    SD_ACTIVE        = 4'b0011,
    SD_WRITE         = 4'b0100,
    SD_READ          = 4'b0101,
    SD_BURST_TERM    = 4'b0110,
    SD_NOP           = 4'b0111
  } sdram_cmd_e;

  typedef struct packed {
    logic aref;
    logic wr;
    logic rd;
  } grant_t;

endpackage

// File: rtl/sdram_pro_arbit_if.sv
// Bundle of the init/refresh/write/read engine buses, their grants and the
// SDRAM pin-side bus. slave = arbiter view, master = engines/pins view.
interface sdram_pro_arbit_if #(
  parameter int ADDR_W = 12,
  parameter int BANK_W = 2,
  parameter int DQ_W   = 16
);

  logic              init_end;
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;
  logic [BANK_W-1:0] init_bank;

  logic              aref_req;
  logic              aref_end;
  logic [3:0]        aref_cmd;
  logic [ADDR_W-1:0] aref_addr;
  logic [BANK_W-1:0] aref_bank;
  logic              aref_en;

  logic              wr_req;
  logic              wr_end;
  logic [3:0]        wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [BANK_W-1:0] wr_bank;
  logic              wr_sdram_en;
  logic [DQ_W-1:0]   wr_sdram_data;
  logic              wr_en;

  logic              rd_req;
  logic              rd_end;
  logic [3:0]        rd_cmd;
  logic [ADDR_W-1:0] rd_addr;
  logic [BANK_W-1:0] rd_bank;
  logic              rd_en;

  logic              sdram_cke;
  logic [3:0]        sdram_cmd;
  logic [ADDR_W-1:0] sdram_addr;
  logic [BANK_W-1:0] sdram_bank;
  logic              sdram_dq_oe;
  logic [DQ_W-1:0]   sdram_dq_out;

  modport slave (
    input  init_end, init_cmd, init_addr, init_bank,
    input  aref_req, aref_end, aref_cmd, aref_addr, aref_bank,
    input  wr_req, wr_end, wr_cmd, wr_addr, wr_bank, wr_sdram_en, wr_sdram_data,
    input  rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
    output aref_en, wr_en, rd_en,
    output sdram_cke, sdram_cmd, sdram_addr, sdram_bank, sdram_dq_oe, sdram_dq_out
  );

  modport master (
    output init_end, init_cmd, init_addr, init_bank,
    output aref_req, aref_end, aref_cmd, aref_addr, aref_bank,
    output wr_req, wr_end, wr_cmd, wr_addr, wr_bank, wr_sdram_en, wr_sdram_data,
    output rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
    input  aref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cmd, sdram_addr, sdram_bank, sdram_dq_oe, sdram_dq_out
  );

endinterface

// File: rtl/sdram_pro_arbit.sv
// SDRAM command-bus arbiter: waits for init, then grants the pins to refresh >
// write > read, each grant running to completion. Define ARBIT_ROUND_ROBIN_EN
// to alternate write/read priority when both are pending.
module sdram_pro_arbit
  import sdram_pro_arbit_pkg::*;
#(
  parameter int         ADDR_W  = 12,
  parameter int         BANK_W  = 2,
  parameter int         DQ_W    = 16,
  parameter logic [3:0] CMD_NOP = SD_NOP
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  sdram_pro_arbit_if.slave  bus
);

  arb_state_e state;
  arb_state_e next_state;
  grant_t     grant_q;
  grant_t     grant_d;
  logic       rd_armed;
  logic       read_turn;

  // NOTE: async reset belongs only on control state; data paths here are
  // purely combinational so nothing wide needs resetting.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= ST_INIT;
      grant_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values together.
      state   <= next_state;
      grant_q <= grant_d;
    end
  end

  // A lingering rd_end from the previous burst must be seen low once before
  // the current READ may end, so a fresh grant is never zero length.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_armed <= 1'b0;
    end else if (state != ST_READ) begin
      rd_armed <= 1'b0;
    end else if (!bus.rd_end) begin
      rd_armed <= 1'b1;
    end
  end

`ifdef ARBIT_ROUND_ROBIN_EN
  logic last_wr;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_wr <= 1'b0;
    end else if (state == ST_WRITE && next_state == ST_ARBIT) begin
      last_wr <= 1'b1;
    end else if (state == ST_READ && next_state == ST_ARBIT) begin
      last_wr <= 1'b0;
    end
  end

  assign read_turn = last_wr;
`else
  assign read_turn = 1'b0;
`endif

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    next_state = state;
    case (state)
      ST_INIT: begin
        if (bus.init_end) next_state = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (bus.aref_req) begin
          next_state = ST_AREF;
        end else if (bus.wr_req && !(bus.rd_req && read_turn)) begin
          next_state = ST_WRITE;
        end else if (bus.rd_req) begin
          next_state = ST_READ;
        end
      end
      ST_AREF: begin
        if (bus.aref_end) next_state = ST_ARBIT;
      end
      ST_WRITE: begin
        if (bus.wr_end) next_state = ST_ARBIT;
      end
      ST_READ: begin
        if (bus.rd_end && rd_armed) next_state = ST_ARBIT;
      end
      default: next_state = ST_INIT;
    endcase

    grant_d.aref = (next_state == ST_AREF);
    grant_d.wr   = (next_state == ST_WRITE);
    grant_d.rd   = (next_state == ST_READ);
  end

  assign bus.aref_en   = grant_q.aref;
  assign bus.wr_en     = grant_q.wr;
  assign bus.rd_en     = grant_q.rd;
  assign bus.sdram_cke = 1'b1;

  // Pin mux: the owner's bus passes straight through; idle drives NOP/all-ones.
  always_comb begin
    bus.sdram_cmd    = CMD_NOP;
    bus.sdram_addr   = {ADDR_W{1'b1}};
    bus.sdram_bank   = {BANK_W{1'b1}};
    bus.sdram_dq_oe  = 1'b0;
    bus.sdram_dq_out = {DQ_W{1'b0}};
    case (state)
      ST_INIT: begin
        bus.sdram_cmd  = bus.init_cmd;
        bus.sdram_addr = bus.init_addr;
        bus.sdram_bank = bus.init_bank;
      end
      ST_AREF: begin
        bus.sdram_cmd  = bus.aref_cmd;
        bus.sdram_addr = bus.aref_addr;
        bus.sdram_bank = bus.aref_bank;
      end
      ST_WRITE: begin
        bus.sdram_cmd    = bus.wr_cmd;
        bus.sdram_addr   = bus.wr_addr;
        bus.sdram_bank   = bus.wr_bank;
        bus.sdram_dq_oe  = bus.wr_sdram_en;
        bus.sdram_dq_out = bus.wr_sdram_data;
      end
      ST_READ: begin
        bus.sdram_cmd  = bus.rd_cmd;
        bus.sdram_addr = bus.rd_addr;
        bus.sdram_bank = bus.rd_bank;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_pro_arbit.sv
// Self-checking bench for sdram_pro_arbit: directed table, hand-written
// multi-cycle sequences and a randomized run against a grant-ownership model.
module tb_sdram_pro_arbit;
  import sdram_pro_arbit_pkg::*;

  localparam int ADDR_W = 12;
  localparam int BANK_W = 2;
  localparam int DQ_W   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_pro_arbit_if #(.ADDR_W(ADDR_W), .BANK_W(BANK_W), .DQ_W(DQ_W)) bus ();

  sdram_pro_arbit #(.ADDR_W(ADDR_W), .BANK_W(BANK_W), .DQ_W(DQ_W)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.init_end = 0; bus.init_cmd = SD_NOP; bus.init_addr = '0; bus.init_bank = '0;
    bus.aref_req = 0; bus.aref_end = 0; bus.aref_cmd = SD_NOP; bus.aref_addr = '0; bus.aref_bank = '0;
    bus.wr_req = 0; bus.wr_end = 0; bus.wr_cmd = SD_NOP; bus.wr_addr = '0; bus.wr_bank = '0;
    bus.wr_sdram_en = 0; bus.wr_sdram_data = '0;
    bus.rd_req = 0; bus.rd_end = 0; bus.rd_cmd = SD_NOP; bus.rd_addr = '0; bus.rd_bank = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    #1;
    check("reset_out", {bus.aref_en, bus.wr_en, bus.rd_en, bus.sdram_cke, bus.sdram_dq_oe, bus.sdram_dq_out},
          {3'b000, 1'b1, 1'b0, 16'h0000});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- reference model: who owns the pins ----------------
  typedef enum {W_BOOT, W_IDLE, W_AREF, W_WR, W_RD} who_e;
  who_e who = W_BOOT;
  bit   rd_low_seen = 1'b0;
`ifdef ARBIT_ROUND_ROBIN_EN
  bit   last_was_wr = 1'b0;
  function automatic bit read_turn();
    return last_was_wr;
  endfunction
`else
  function automatic bit read_turn();
    return 1'b0;
  endfunction
`endif

  function automatic logic [63:0] model_out();
    logic [2:0]        g;
    logic              oe;
    logic [DQ_W-1:0]   d;
    logic [3:0]        c;
    logic [ADDR_W-1:0] a;
    logic [BANK_W-1:0] b;
    g = 3'b000; oe = 1'b0; d = '0; c = SD_NOP; a = '1; b = '1;
    case (who)
      W_BOOT: begin c = bus.init_cmd; a = bus.init_addr; b = bus.init_bank; end
      W_AREF: begin g = 3'b100; c = bus.aref_cmd; a = bus.aref_addr; b = bus.aref_bank; end
      W_WR: begin
        g = 3'b010; c = bus.wr_cmd; a = bus.wr_addr; b = bus.wr_bank;
        oe = bus.wr_sdram_en; d = bus.wr_sdram_data;
      end
      W_RD: begin g = 3'b001; c = bus.rd_cmd; a = bus.rd_addr; b = bus.rd_bank; end
      default: ;
    endcase
    return {26'd0, g, oe, d, c, a, b};
  endfunction

  function automatic logic [63:0] actual_word();
    return {26'd0, bus.aref_en, bus.wr_en, bus.rd_en, bus.sdram_dq_oe, bus.sdram_dq_out,
            bus.sdram_cmd, bus.sdram_addr, bus.sdram_bank};
  endfunction

  task automatic model_edge();
    case (who)
      W_BOOT: if (bus.init_end) who = W_IDLE;
      W_IDLE: begin
        if (bus.aref_req) who = W_AREF;
        else if (bus.rd_req && (!bus.wr_req || read_turn())) begin
          who = W_RD;
          rd_low_seen = 1'b0;
        end else if (bus.wr_req) who = W_WR;
      end
      W_AREF: if (bus.aref_end) who = W_IDLE;
      W_WR: if (bus.wr_end) begin
        who = W_IDLE;
`ifdef ARBIT_ROUND_ROBIN_EN
        last_was_wr = 1'b1;
`endif
      end
      W_RD: begin
        if (!bus.rd_end) rd_low_seen = 1'b1;
        else if (rd_low_seen) begin
          who = W_IDLE;
`ifdef ARBIT_ROUND_ROBIN_EN
          last_was_wr = 1'b0;
`endif
        end
      end
      default: who = W_BOOT;
    endcase
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [6:0] stim;  // {init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end}
    logic [2:0] en;    // {aref_en, wr_en, rd_en}
    logic       oe;
    logic [3:0] cmd;
  } vec_t;

  vec_t tbl [20];

  initial begin
    logic [3:0]      burst_cmd [11];
    logic [DQ_W-1:0] data_k;
    logic            en_k;
    int              oe_cnt;
    logic [3:0]      order;
    int              n_grants;
    int              wc, rc;
    logic            pw, pr;
    logic [3:0]      exp_order;

    clear_inputs();

    // Reset values, then init muxing while init_end is low.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bus.init_cmd  = i[0] ? SD_PRECHARGE : SD_AUTO_REFRESH;
      bus.init_addr = ADDR_W'($urandom);
      bus.init_bank = BANK_W'($urandom);
      @(negedge clk);
      check("init_mux", {bus.aref_en, bus.wr_en, bus.rd_en, bus.sdram_cmd, bus.sdram_addr, bus.sdram_bank},
            {3'b000, bus.init_cmd, bus.init_addr, bus.init_bank});
    end
    @(posedge clk); #1;
    bus.init_end = 1'b1;
    @(negedge clk);
    check("init_last", bus.sdram_cmd, bus.init_cmd);
    @(posedge clk); #1;
    @(negedge clk);
    check("arbit_nop", {bus.sdram_cmd, bus.sdram_addr, bus.sdram_bank}, {4'b0111, 12'hfff, 2'b11});

    // Priority, NOP gap, no preemption, stale rd_end, ignored *_end / init_end.
    bus.aref_cmd = SD_AUTO_REFRESH; bus.wr_cmd = SD_WRITE; bus.rd_cmd = SD_READ;
    bus.wr_sdram_en = 1'b1; bus.wr_sdram_data = 16'h5a5a;
    tbl[0]  = '{7'b1101010, 3'b000, 1'b0, 4'b0111};
    tbl[1]  = '{7'b1001010, 3'b100, 1'b0, 4'b0001};
    tbl[2]  = '{7'b1011010, 3'b100, 1'b0, 4'b0001};
    tbl[3]  = '{7'b1001010, 3'b000, 1'b0, 4'b0111};
    tbl[4]  = '{7'b1000010, 3'b010, 1'b1, 4'b0100};
    tbl[5]  = '{7'b1000110, 3'b010, 1'b1, 4'b0100};
    tbl[6]  = '{7'b1000010, 3'b000, 1'b0, 4'b0111};
    tbl[7]  = '{7'b1000000, 3'b001, 1'b0, 4'b0101};
    tbl[8]  = '{7'b1100000, 3'b001, 1'b0, 4'b0101};
    tbl[9]  = '{7'b1100001, 3'b001, 1'b0, 4'b0101};
    tbl[10] = '{7'b1100011, 3'b000, 1'b0, 4'b0111};
    tbl[11] = '{7'b1010011, 3'b100, 1'b0, 4'b0001};
    tbl[12] = '{7'b1000011, 3'b000, 1'b0, 4'b0111};
    tbl[13] = '{7'b1000001, 3'b001, 1'b0, 4'b0101};
    tbl[14] = '{7'b1000001, 3'b001, 1'b0, 4'b0101};
    tbl[15] = '{7'b1000000, 3'b001, 1'b0, 4'b0101};
    tbl[16] = '{7'b1000001, 3'b001, 1'b0, 4'b0101};
    tbl[17] = '{7'b0000001, 3'b000, 1'b0, 4'b0111};
    tbl[18] = '{7'b0010100, 3'b000, 1'b0, 4'b0111};
    tbl[19] = '{7'b0000000, 3'b000, 1'b0, 4'b0111};
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      {bus.init_end, bus.aref_req, bus.aref_end, bus.wr_req, bus.wr_end, bus.rd_req, bus.rd_end} = tbl[i].stim;
      @(negedge clk);
      check($sformatf("table_%0d", i), {bus.aref_en, bus.wr_en, bus.rd_en, bus.sdram_dq_oe, bus.sdram_cmd},
            {tbl[i].en, tbl[i].oe, tbl[i].cmd});
    end

    // Write burst of 8 data beats.
    burst_cmd[0] = SD_NOP; burst_cmd[1] = SD_ACTIVE; burst_cmd[2] = SD_WRITE;
    for (int k = 3; k < 10; k++) burst_cmd[k] = SD_NOP;
    burst_cmd[10] = SD_PRECHARGE;
    @(posedge clk); #1;
    bus.init_end = 1'b1; bus.wr_req = 1'b1; bus.wr_sdram_en = 1'b0;
    @(negedge clk);
    check("burst_arbit", {bus.wr_en, bus.sdram_cmd}, {1'b0, 4'b0111});
    oe_cnt = 0;
    for (int k = 0; k < 11; k++) begin
      @(posedge clk); #1;
      bus.wr_req        = 1'b0;
      bus.wr_cmd        = burst_cmd[k];
      en_k              = (k >= 2 && k < 10);
      data_k            = DQ_W'($urandom);
      bus.wr_sdram_en   = en_k;
      bus.wr_sdram_data = data_k;
      bus.wr_end        = (k == 10);
      @(negedge clk);
      if (bus.sdram_dq_oe) oe_cnt++;
      check($sformatf("burst_%0d", k), {bus.wr_en, bus.sdram_dq_oe, bus.sdram_dq_out, bus.sdram_cmd},
            {1'b1, en_k, data_k, burst_cmd[k]});
    end
    @(posedge clk); #1;
    bus.wr_end = 1'b0; bus.wr_sdram_en = 1'b1;
    @(negedge clk);
    check("burst_after", {bus.wr_en, bus.sdram_dq_oe, bus.sdram_dq_out, bus.sdram_cmd},
          {1'b0, 1'b0, 16'h0000, 4'b0111});
    check("burst_oe_cycles", oe_cnt, 8);

    // Write and read both held: alternate with round robin, else write only.
    order = 4'b0000; n_grants = 0; wc = 0; rc = 0; pw = 0; pr = 0;
    bus.wr_sdram_en = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk); #1;
      wc = bus.wr_en ? wc + 1 : 0;
      rc = bus.rd_en ? rc + 1 : 0;
      bus.wr_end = (wc == 2);
      bus.rd_end = (rc == 2);
      bus.wr_req = (n_grants < 4);
      bus.rd_req = (n_grants < 4);
      @(negedge clk);
      if (bus.wr_en && !pw) begin order = {order[2:0], 1'b1}; n_grants++; end
      if (bus.rd_en && !pr) begin order = {order[2:0], 1'b0}; n_grants++; end
      pw = bus.wr_en; pr = bus.rd_en;
    end
`ifdef ARBIT_ROUND_ROBIN_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b1111;
`endif
    check("rr_grant_count", n_grants, 4);
    check("rr_order", order, exp_order);

    // Reset in the middle of a write burst.
    @(posedge clk); #1;
    bus.wr_end = 1'b0; bus.rd_end = 1'b0;
    bus.init_cmd = SD_PRECHARGE; bus.wr_req = 1'b1; bus.wr_cmd = SD_ACTIVE; bus.wr_sdram_en = 1'b1;
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    @(negedge clk);
    check("rst_burst_pre", {bus.wr_en, bus.sdram_dq_oe, bus.sdram_cmd}, {1'b1, 1'b1, SD_ACTIVE});
    #2 rst_n = 1'b0;
    #1;
    check("rst_burst_drop", {bus.wr_en, bus.sdram_dq_oe, bus.sdram_cmd}, {1'b0, 1'b0, SD_PRECHARGE});
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run against the ownership model, two reset epochs.
    for (int epoch = 0; epoch < 2; epoch++) begin
      do_reset();
      who = W_BOOT;
      rd_low_seen = 1'b0;
`ifdef ARBIT_ROUND_ROBIN_EN
      last_was_wr = 1'b0;
`endif
      for (int c = 0; c < 1500; c++) begin
        @(posedge clk); #1;
        bus.init_end      = (who == W_BOOT) ? ($urandom_range(7) == 0) : 1'($urandom_range(1));
        bus.init_cmd      = 4'($urandom); bus.init_addr = ADDR_W'($urandom); bus.init_bank = BANK_W'($urandom);
        bus.aref_req      = ($urandom_range(4) == 0);
        bus.aref_end      = ($urandom_range(2) == 0);
        bus.aref_cmd      = 4'($urandom); bus.aref_addr = ADDR_W'($urandom); bus.aref_bank = BANK_W'($urandom);
        bus.wr_req        = ($urandom_range(2) == 0);
        bus.wr_end        = ($urandom_range(3) == 0);
        bus.wr_cmd        = 4'($urandom); bus.wr_addr = ADDR_W'($urandom); bus.wr_bank = BANK_W'($urandom);
        bus.wr_sdram_en   = 1'($urandom_range(1));
        bus.wr_sdram_data = DQ_W'($urandom);
        bus.rd_req        = ($urandom_range(2) == 0);
        bus.rd_end        = 1'($urandom_range(1));
        bus.rd_cmd        = 4'($urandom); bus.rd_addr = ADDR_W'($urandom); bus.rd_bank = BANK_W'($urandom);
        @(negedge clk);
        check("random", actual_word(), model_out());
        model_edge();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
